// File: rtl/mux_dual.sv
`default_nettype none
// ============================================================================
//  Module   : mux_dual
//  Brief    : Two-stage cascaded selector with registered outputs.
//             Stage 1 picks a or b; stage 2 picks c or the stage-1 pick.
//             Both results are captured on the same edge from the same
//             input sample, giving a 3:1 path on ot_2 with 1-cycle latency.
//  Revision : 1.0  initial release
// ============================================================================
module mux_dual #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             sel_1,
  input  logic             sel_2,
  input  logic             in_valid,
  output logic [WIDTH-1:0] ot_1,
  output logic [WIDTH-1:0] ot_2,
  output logic             out_valid
);

  // Reject widths outside the supported range at elaboration time.
  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("mux_dual: WIDTH must be in 1..64");
  end

  logic [WIDTH-1:0] w_s1;
  logic [WIDTH-1:0] w_s2;
  logic [WIDTH-1:0] r_ot_1;
  logic [WIDTH-1:0] r_ot_2;
  logic             r_out_valid;

  // Both selection stages resolve in the same cycle; stage 2 consumes the
  // live stage-1 result, not the registered ot_1, so the two outputs always
  // describe the same input sample.
  always_comb begin
    w_s1 = a;
    w_s2 = c;
    w_s1 = sel_1 ? b : a;
    w_s2 = sel_2 ? c : w_s1;
  end

  // Capture on valid input, otherwise hold data and drop valid; async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ot_1      <= '0;
      r_ot_2      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_ot_1 <= w_s1;
        r_ot_2 <= w_s2;
      end
    end
  end

  assign ot_1      = r_ot_1;
  assign ot_2      = r_ot_2;
  assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_dual.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_dual
//  Brief    : Scoreboard bench for mux_dual (WIDTH=8). Stimulus pushes the
//             expected pair for every valid sample; a monitor pops on
//             out_valid and checks held values when out_valid is low.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_dual;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] e1;
    logic [W-1:0] e2;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] c = '0;
  logic         sel_1 = 1'b0;
  logic         sel_2 = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] ot_1;
  logic [W-1:0] ot_2;
  logic         out_valid;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mux_dual #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .c        (c),
    .sel_1    (sel_1),
    .sel_2    (sel_2),
    .in_valid (in_valid),
    .ot_1     (ot_1),
    .ot_2     (ot_2),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
  endtask

  // Reference: the selector as stated in words, result pair per sample.
  function automatic exp_t ref_model(input logic s1, input logic s2,
                                     input logic [W-1:0] ia, input logic [W-1:0] ib,
                                     input logic [W-1:0] ic);
    exp_t r;
    r.e1 = (s1 == 1'b1) ? ib : ia;
    r.e2 = (s2 == 1'b1) ? ic : r.e1;
    return r;
  endfunction

  // Present one input sample just after a rising edge; it is captured on the next.
  task automatic step(input logic v, input logic s1, input logic s2,
                      input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic);
    @(posedge clk);
    #1;
    a = ia; b = ib; c = ic; sel_1 = s1; sel_2 = s2; in_valid = v;
    if (v && rst_n) exp_q.push_back(ref_model(s1, s2, ia, ib, ic));
  endtask

  // Monitor: pop on out_valid, otherwise outputs must hold the last result.
  initial begin : monitor
    logic [W-1:0] last1;
    logic [W-1:0] last2;
    exp_t e;
    last1 = '0;
    last2 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ot_1", 64'(ot_1), 64'(0));
        chk("rst_ot_2", 64'(ot_2), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        last1 = '0;
        last2 = '0;
      end else if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("ot_1", 64'(ot_1), 64'(e.e1));
          chk("ot_2", 64'(ot_2), 64'(e.e2));
          last1 = e.e1;
          last2 = e.e2;
        end
      end else begin
        chk("hold_ot_1", 64'(ot_1), 64'(last1));
        chk("hold_ot_2", 64'(ot_2), 64'(last2));
      end
    end
  end

  initial begin : stimulus
    logic [W-1:0] ra, rb, rc;
    // Reset held from time 0; release between edges.
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Stage-1 select a.
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h01);
    // Stage-1 select b, then b changes to 1.
    step(1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00);
    // Stage-2 select c.
    step(1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 8'hA5);
    // Load 0x22 then hold with idle cycles and churning inputs.
    step(1'b1, 1'b1, 1'b0, 8'h11, 8'h22, 8'h33);
    step(1'b0, 1'b0, 1'b1, 8'hFF, 8'hEE, 8'hDD);
    step(1'b0, 1'b1, 1'b1, 8'h5A, 8'hC3, 8'h3C);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 8'h77);
    // Back-to-back through all four select combinations.
    step(1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 8'h30);
    step(1'b1, 1'b0, 1'b1, 8'h11, 8'h21, 8'h31);
    step(1'b1, 1'b1, 1'b0, 8'h12, 8'h22, 8'h32);
    step(1'b1, 1'b1, 1'b1, 8'h13, 8'h23, 8'h33);

    // Load a nonzero value, then assert reset asynchronously mid-cycle.
    step(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ot_1", 64'(ot_1), 64'(0));
    chk("async_rst_ot_2", 64'(ot_2), 64'(0));
    chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    exp_q.delete();
    // Data presented during reset must be discarded.
    step(1'b1, 1'b1, 1'b1, 8'hAB, 8'hCD, 8'hEF);
    step(1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h56);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Randomised traffic with roughly 75% valid density.
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom());
      rb = W'($urandom());
      rc = W'($urandom());
      step(($urandom_range(0, 3) != 0), 1'($urandom()), 1'($urandom()), ra, rb, rc);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
